fp_sang_tp: RTL and testbench

FP_SANG_TP -- requirements
Module: fp_sang_tp

---
 rtl/fp_sang_tp_pkg.sv | 15 +
 rtl/fp32_field_decode.sv | 37 +++
 rtl/fp_sang_tp.sv | 88 ++++++++
 tb/tb_fp_sang_tp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_sang_tp_pkg.sv
// Shared binary32 field layout and fixed-point saturation constants for the
// float-to-fixed converter.
package fp_sang_tp_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int SIG_W    = MANT_W + 1;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT = 32'h8000_0000;

endpackage

// File: rtl/fp32_field_decode.sv
// Splits a binary32 word into sign, biased exponent and significand and
// classifies it as zero, subnormal, infinity or NaN.
module fp32_field_decode
  import fp_sang_tp_pkg::*;
(
  input  logic [31:0]       a,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [SIG_W-1:0]  significand,
  output logic              is_zero,
  output logic              is_sub,
  output logic              is_inf,
  output logic              is_nan
);

  logic [MANT_W-1:0] mantissa;
  logic              exp_zero;
  logic              exp_max;
  logic              mant_zero;

  assign sign      = a[31];
  assign exponent  = a[30:23];
  assign mantissa  = a[22:0];

  assign exp_zero  = (exponent == '0);
  assign exp_max   = (exponent == EXP_MAX);
  assign mant_zero = (mantissa == '0);

  // Hidden bit is present only for normal numbers.
  assign significand = {~exp_zero, mantissa};

  assign is_zero = exp_zero & mant_zero;
  assign is_sub  = exp_zero & ~mant_zero;
  assign is_inf  = exp_max & mant_zero;
  assign is_nan  = exp_max & ~mant_zero;

endmodule

// File: rtl/fp_sang_tp.sv
// Single-cycle binary32 to signed Q(XLEN-FRAC_BITS).FRAC_BITS converter with
// truncation toward zero and saturation; XLEN matches the 32-bit input format.
module fp_sang_tp
  import fp_sang_tp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic            in_valid,
  output logic [XLEN-1:0] result,
  output logic            out_valid
);

  localparam logic signed [9:0] SHIFT_OFFSET = 10'(EXP_BIAS + MANT_W - FRAC_BITS);
  localparam logic signed [9:0] SAT_SHIFT    = 10'(XLEN - SIG_W);
  localparam logic [9:0]        RSHIFT_ZERO  = 10'(SIG_W);
  localparam logic [XLEN-1:0]   POS_VAL      = XLEN'(POS_SAT);
  localparam logic [XLEN-1:0]   NEG_VAL      = XLEN'(NEG_SAT);

  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic [SIG_W-1:0]  significand;
  logic              is_zero;
  logic              is_sub;
  logic              is_inf;
  logic              is_nan;

  logic signed [9:0] shift;
  logic [9:0]        rshift;
  logic [XLEN-1:0]   sig_ext;
  logic [XLEN-1:0]   mag;
  logic [XLEN-1:0]   conv;

  fp32_field_decode u_decode (
    .a           (a[31:0]),
    .sign        (sign),
    .exponent    (exponent),
    .significand (significand),
    .is_zero     (is_zero),
    .is_sub      (is_sub),
    .is_inf      (is_inf),
    .is_nan      (is_nan)
  );

  // Positive shift moves the binary point right of the significand LSB.
  assign shift   = $signed({2'b00, exponent}) - SHIFT_OFFSET;
  assign rshift  = unsigned'(-shift);
  assign sig_ext = {{(XLEN-SIG_W){1'b0}}, significand};

  // Once the significand MSB reaches the sign bit the value is out of range;
  // the lone in-range case there (-2^(XLEN-FRAC_BITS-1)) equals NEG_VAL anyway.
  always_comb begin
    mag  = '0;
    conv = '0;
    if (is_nan) begin
      conv = POS_VAL;
    end else if (is_inf) begin
      conv = sign ? NEG_VAL : POS_VAL;
    end else if (is_zero || is_sub) begin
      conv = '0;
    end else if (shift >= SAT_SHIFT) begin
      conv = sign ? NEG_VAL : POS_VAL;
    end else begin
      if (!shift[9]) begin
        mag = sig_ext << unsigned'(shift);
      end else if (rshift < RSHIFT_ZERO) begin
        mag = sig_ext >> rshift;
      end
      conv = sign ? -mag : mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= conv;
      end
    end
  end

endmodule

// File: tb/tb_fp_sang_tp.sv
// Scoreboard bench for fp_sang_tp: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against each out_valid pulse.
module tb_fp_sang_tp;

  typedef struct {
    logic [31:0] a;
    logic [31:0] expected;
    int          due;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic        in_valid;
  logic [31:0] result;
  logic        out_valid;

  sb_entry_t   sb[$];
  sb_entry_t   mon_entry;
  int          cycle;
  int          checks;
  int          errors;

  logic [31:0] single_a[16];
  logic [31:0] single_exp[16];
  logic [31:0] burst_a[5];
  logic [31:0] burst_exp[5];

  fp_sang_tp #(.XLEN(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Latency is checked via the cycle each expectation was due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("[TB] FAIL unexpected_out_valid: actual result=%h required=no output", result);
        end else begin
          mon_entry = sb.pop_front();
          if (result !== mon_entry.expected || cycle != mon_entry.due) begin
            errors = errors + 1;
            $display("[TB] FAIL conv_%h: actual=%h@%0d required=%h@%0d",
                     mon_entry.a, result, cycle, mon_entry.expected, mon_entry.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cycle) begin
        mon_entry = sb.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL missing_%h: actual=no out_valid required=%h", mon_entry.a, mon_entry.expected);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] val, input logic [31:0] expected);
    sb_entry_t e;
    @(posedge clk);
    #1;
    a        = val;
    in_valid = 1'b1;
    e.a        = val;
    e.expected = expected;
    e.due      = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  initial begin
    single_a[0]  = 32'h404CCCCD; single_exp[0]  = 32'h0003_3333;
    single_a[1]  = 32'h40066666; single_exp[1]  = 32'h0002_1999;
    single_a[2]  = 32'h428C3EFA; single_exp[2]  = 32'h0046_1F7D;
    single_a[3]  = 32'h4171999A; single_exp[3]  = 32'h000F_1999;
    single_a[4]  = 32'hBDFC2880; single_exp[4]  = 32'hFFFF_E07B;
    single_a[5]  = 32'h47800000; single_exp[5]  = 32'h7FFF_FFFF;
    single_a[6]  = 32'hC7000000; single_exp[6]  = 32'h8000_0000;
    single_a[7]  = 32'hFF800000; single_exp[7]  = 32'h8000_0000;
    single_a[8]  = 32'h7FC00000; single_exp[8]  = 32'h7FFF_FFFF;
    single_a[9]  = 32'h80000000; single_exp[9]  = 32'h0000_0000;
    single_a[10] = 32'h00000001; single_exp[10] = 32'h0000_0000;
    single_a[11] = 32'h33800000; single_exp[11] = 32'h0000_0000;
    single_a[12] = 32'h7F800000; single_exp[12] = 32'h7FFF_FFFF;
    single_a[13] = 32'h47000000; single_exp[13] = 32'h7FFF_FFFF;
    single_a[14] = 32'hC7000080; single_exp[14] = 32'h8000_0000;
    single_a[15] = 32'hBFC00000; single_exp[15] = 32'hFFFE_8000;

    burst_a[0] = 32'h404CCCCD; burst_exp[0] = 32'h0003_3333;
    burst_a[1] = 32'h428C3EFA; burst_exp[1] = 32'h0046_1F7D;
    burst_a[2] = 32'h4171999A; burst_exp[2] = 32'h000F_1999;
    burst_a[3] = 32'hBDFC2880; burst_exp[3] = 32'hFFFF_E07B;
    burst_a[4] = 32'h4034B4B5; burst_exp[4] = 32'h0002_D2D2;

    checks   = 0;
    errors   = 0;
    cycle    = 0;
    rst_n    = 1'b0;
    a        = 32'h0;
    in_valid = 1'b0;

    #2;
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(single_a[i], single_exp[i]);
      idleCycle();
    end
    idleCycle();
    idleCycle();
    checkOutput("hold_result", result, 32'hFFFE_8000);
    checkOutput("hold_valid", 32'(out_valid), 32'h0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(burst_a[i], burst_exp[i]);
    end

    // A sixth input is captured, then reset lands while its result is showing
    // and while a seventh input is still being offered.
    @(posedge clk);
    #1;
    a = 32'h3F800000;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_result", result, 32'h0001_0000);
    a = 32'hC0000000;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_result", result, 32'h0);
    checkOutput("midreset_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("held_reset_result", result, 32'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("post_reset_result", result, 32'h0);
    checkOutput("post_reset_valid", 32'(out_valid), 32'h0);

    applyStimulus(32'hC0000000, 32'hFFFE_0000);
    idleCycle();

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
